instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage of the 16-bit CPU; sits directly upstream of ip_rom and downstream into decode.
//  Owns the program counter and drives the ROM address (rom_addr -> ip_rom.addra).
//  Captures the returned word (ip_rom.douta -> rom_data) into an instruction register.
//  Hands that instruction to decode over a valid/ready handshake; supports branch redirect and HALT.
// PARAMETERS
//  ADDR_W    4      ROM address / PC width
//  DATA_W    16     instruction width
//  RESET_PC  0      PC value after reset
//  HALT_OP   4'hF   opcode (ir[15:12]) that stops fetching
// PORTS
//  sys_clk    in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  fetch_en   in   1       1 = run; sampled in IDLE and when leaving HOLD
//  rom_addr   out  ADDR_W  ROM address, equals PC register
//  rom_data   in   DATA_W  ROM read data, valid 1 cycle after rom_addr
//  ir         out  DATA_W  instruction to decode
//  ir_pc      out  ADDR_W  address ir was fetched from
//  ir_valid   out  1       ir holds an unconsumed instruction
//  ir_ready   in   1       decode accepts ir when ir_valid & ir_ready
//  br_valid   in   1       branch redirect request, single cycle
//  br_target  in   ADDR_W  new PC on br_valid
//  halted     out  1       HALT retired; fetch stopped until reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   pc = rom_addr = RESET_PC; ir = 0, ir_pc = 0, ir_valid = 0, halted = 0; state = IDLE.
//  ROM contract: synchronous read. Address in cycle c gives rom_data in cycle c+1.
//  States:
//   IDLE: fetch_en=1 -> REQ.
//   REQ:  rom_addr = pc -> CAP.
//   CAP:  ir <= rom_data, ir_pc <= pc, ir_valid <= 1, pc <= pc+1 -> HOLD.
//   HOLD: waits for ir_valid & ir_ready. On handshake, ir_valid <= 0 and:
//         - ir[15:12]==HALT_OP -> HALT.
//         - else fetch_en=1 -> REQ.
//         - else -> IDLE.
//   HALT: halted=1, ir_valid=0; no state change until reset.
//  Throughput: 1 instruction per 3 cycles with ir_ready tied high.
//   ir_valid rises in the 3rd cycle after entering REQ.
//  Handshake rules:
//   ir, ir_pc stable while ir_valid=1 and no handshake.
//   ir_valid never drops without a handshake, except on a branch.
//  Branch (br_valid=1), any state except HALT; has priority over all other transitions:
//   pc <= br_target; ir_valid <= 0; next state REQ, or IDLE if current state is IDLE.
//   In CAP: the ROM word is discarded; ir is not updated.
//   In HOLD with a simultaneous handshake: the instruction counts as consumed, but a HALT opcode in it is ignored.
//   In HALT: br_valid is ignored.
//  PC arithmetic: pc+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
//  fetch_en=0 never aborts a fetch in REQ/CAP/HOLD; it takes effect only at the HOLD exit.
//  Mid-operation reset: all state and outputs go to reset values immediately; no partial instruction survives.
// TESTING
//  1. ROM[0..3] = 1111h,2222h,3333h,4444h; ir_ready=1; fetch_en=1 at t0
//     -> ir = 1111h/2222h/3333h with ir_pc = 0/1/2, each ir_valid pulse spaced 3 cycles.
//  2. ir_ready=0 for 5 cycles while ir=2222h
//     -> ir_valid held 1, ir/ir_pc stable, rom_addr=2; resumes at 3333h after ready.
//  3. br_valid, br_target=9 during CAP of addr 1
//     -> 2222h never presented; next ir = ROM[9], ir_pc = 9.
//  4. ADDR_W=4, PC=15, ROM[15]=0ABCh
//     -> after the 0ABCh handshake, rom_addr=0 and next ir_pc=0.
//  5. ROM[2] = F000h
//     -> after its handshake: halted=1, ir_valid stays 0, br_valid ignored, rom_addr stays 3.
//  6. rst_n=0 for 1 cycle while in HOLD with ir_valid=1
//     -> ir_valid=0, rom_addr=RESET_PC at once; refetch starts from ROM[0].

Source files
------------

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bus bundle around the instruction fetch stage.
//   ROM side    : rom_addr (fetch -> ROM), rom_data (ROM -> fetch)
//   Decode side : ir, ir_pc, ir_valid (fetch -> decode), ir_ready (decode -> fetch)
//   Control     : fetch_en, br_valid, br_target (into fetch), halted (out of fetch)
// Modports:
//   master : the fetch stage itself
//   slave  : everything around it (ROM, decode, branch unit, run control)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              fetch_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              halted;

    modport master (
        input  fetch_en,
        output rom_addr,
        input  rom_data,
        output ir,
        output ir_pc,
        output ir_valid,
        input  ir_ready,
        input  br_valid,
        input  br_target,
        output halted
    );

    modport slave (
        output fetch_en,
        input  rom_addr,
        output rom_data,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        output ir_ready,
        output br_valid,
        output br_target,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the 16-bit CPU. Owns the PC, drives the synchronous ROM
// address, captures the returned word into the instruction register and
// offers it to decode over a valid/ready handshake. Supports single-cycle
// branch redirects and stops permanently (until reset) on a HALT opcode.
// Ports:
//   sys_clk : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : instr_fetch_if.master (ROM, decode handshake, branch, run control)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [DATA_W-1:0] ir_r, ir_nxt_s;
    logic [ADDR_W-1:0] ir_pc_r, ir_pc_nxt_s;
    logic              ir_valid_r, ir_valid_nxt_s;
    logic              halted_r, halted_nxt_s;

    logic              handshake_s;
    logic              is_halt_s;
    logic              branch_s;

    assign handshake_s = ir_valid_r & bus.ir_ready;
    assign is_halt_s   = (ir_r[DATA_W-1 -: 4] == HALT_OP);
    // A halted core ignores redirects entirely.
    assign branch_s    = bus.br_valid & (state_r != S_HALT);

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a branch overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (branch_s) begin
                    state_nxt_s = S_IDLE;
                end else if (bus.fetch_en) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (branch_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_CAP;
                end
            end
            S_CAP: begin
                if (branch_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_s) begin
                    // A simultaneous handshake still consumes the word, but its
                    // HALT opcode (if any) loses to the redirect.
                    state_nxt_s = S_REQ;
                end else if (handshake_s) begin
                    if (is_halt_s) begin
                        state_nxt_s = S_HALT;
                    end else if (bus.fetch_en) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Next values of PC, instruction register and status outputs.
    always_comb begin
        pc_nxt_s       = pc_r;
        ir_nxt_s       = ir_r;
        ir_pc_nxt_s    = ir_pc_r;
        ir_valid_nxt_s = ir_valid_r;
        halted_nxt_s   = halted_r;
        if (branch_s) begin
            // In CAP the ROM word for the old PC is simply not captured.
            pc_nxt_s       = bus.br_target;
            ir_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                S_CAP: begin
                    ir_nxt_s       = bus.rom_data;
                    ir_pc_nxt_s    = pc_r;
                    ir_valid_nxt_s = 1'b1;
                    pc_nxt_s       = pc_r + PC_ONE;   // wraps modulo 2^ADDR_W
                end
                S_HOLD: begin
                    if (handshake_s) begin
                        ir_valid_nxt_s = 1'b0;
                        halted_nxt_s   = is_halt_s;
                    end else begin
                        ir_valid_nxt_s = 1'b1;
                    end
                end
                S_HALT: begin
                    ir_valid_nxt_s = 1'b0;
                    halted_nxt_s   = 1'b1;
                end
                default: begin
                    ir_valid_nxt_s = ir_valid_r;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            ir_r       <= '0;
            ir_pc_r    <= '0;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            ir_r       <= ir_nxt_s;
            ir_pc_r    <= ir_pc_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            halted_r   <= halted_nxt_s;
        end
    end

    assign bus.rom_addr = pc_r;
    assign bus.ir       = ir_r;
    assign bus.ir_pc    = ir_pc_r;
    assign bus.ir_valid = ir_valid_r;
    assign bus.halted   = halted_r;

endmodule
